// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - multi-cycle MIPS control FSM (optional MCC_MEM_WAIT_EN memory handshake)
module multi_cycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_opcode;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_mem_ok;

`ifdef MCC_MEM_WAIT_EN
    assign w_mem_ok = mem_ready;
`else
    // Without the handshake every memory access completes in one cycle.
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok = 1'b1;
`endif

    // State register plus the opcode captured while in DECODE, so MEM_ADDR
    // does not depend on the IR still holding the same instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_opcode <= 6'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_opcode <= opcode;
        end
    end

    // Next-state logic; memory states hold until the access completes.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:     w_next = w_mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_RTYPE:     w_next = S_R_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_I_EXEC;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  w_next = (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  w_next = w_mem_ok ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next = w_mem_ok ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    w_next = S_R_WB;
            S_I_EXEC:    w_next = S_I_WB;
            default:     w_next = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every control line low so an
    // aborted instruction cannot issue a partial write.
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        i_or_d          = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        instr_done      = 1'b0;
        illegal_op      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                ir_write   = w_mem_ok;
                w_pc_write = w_mem_ok;
                alu_src_b  = 2'b01;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
                instr_done      = 1'b1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL:  illegal_op = 1'b1;
            default:    ;
        endcase
        if (reset) begin
            w_pc_write      = 1'b0;
            w_pc_write_cond = 1'b0;
            i_or_d          = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            ir_write        = 1'b0;
            reg_dst         = 1'b0;
            mem_to_reg      = 1'b0;
            reg_write       = 1'b0;
            alu_src_a       = 1'b0;
            alu_src_b       = 2'b00;
            alu_op          = 2'b00;
            pc_source       = 2'b00;
            instr_done      = 1'b0;
            illegal_op      = 1'b0;
        end
    end

    assign pc_en = w_pc_write | (w_pc_write_cond & zero);
    assign state = r_state;

endmodule
